// File: rtl/channel_pkg.sv
// Shared definitions for the I/Q channel emulator: phase codes, LFSR taps, saturating helpers.
// Helpers work on int so they stay width-generic; w is the signed result width.
package channel_pkg;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_HEAD = 2'd1;
  localparam logic [1:0] PH_DATA = 2'd2;
  localparam logic [1:0] PH_REST = 2'd3;

  // Fibonacci taps (shift-left form): x^8+x^6+x^5+x^4+1 and x^16+x^14+x^13+x^11+1
  localparam logic [15:0] TAPS_8  = 16'h00B8;
  localparam logic [15:0] TAPS_16 = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE = PH_IDLE,
    ST_HEAD = PH_HEAD,
    ST_DATA = PH_DATA,
    ST_REST = PH_REST
  } state_e;

  function automatic logic [15:0] lfsr_taps(input int len);
    return (len == 16) ? TAPS_16 : TAPS_8;
  endfunction

  // The int intermediate is wider than w+1 bits, so the sum can never wrap before clamping.
  function automatic int sat_add(input int a, input int b, input int w);
    int s;
    int hi;
    int lo;
    s  = a + b;
    hi = (1 << (w - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  function automatic int sat_neg(input int a, input int w);
    return sat_add(-a, 0, w);
  endfunction

endpackage

// File: rtl/channel_model_if.sv
// Symbol-side and channel-side signals of the emulator, grouped for the top-level port.
// The master side drives symbols and controls; the slave side (the emulator) drives results.
interface channel_model_if #(
  parameter int W = 4
);
  logic                has_error;
  logic                IsTransmit;
  logic [7:0]          err_period;
  logic signed [W-1:0] I_in;
  logic signed [W-1:0] Q_in;
  logic signed [W-1:0] I_out;
  logic signed [W-1:0] Q_out;
  logic                out_valid;
  logic [1:0]          phase;
  logic                err_flag;

  modport master (
    output has_error, IsTransmit, err_period, I_in, Q_in,
    input  I_out, Q_out, out_valid, phase, err_flag
  );

  modport slave (
    input  has_error, IsTransmit, err_period, I_in, Q_in,
    output I_out, Q_out, out_valid, phase, err_flag
  );
endinterface

// File: rtl/channel_model_noise_lfsr.sv
// Per-lane noise source: free-running Fibonacci LFSR, low NOISE_BITS sign-extended to W.
// Combinational output from the current LFSR state; advances every non-reset cycle, never stalls.
module noise_lfsr
  import channel_pkg::*;
#(
  parameter int                W          = 4,
  parameter int                LFSR_W     = 8,
  parameter int                NOISE_BITS = 2,
  parameter logic [LFSR_W-1:0] SEED       = 1
) (
  input  logic                clk,
  input  logic                reset,
  output logic signed [W-1:0] noise
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
    end
  end

  assign noise = {{(W - NOISE_BITS){lfsr[NOISE_BITS-1]}}, lfsr[NOISE_BITS-1:0]};

endmodule

// File: rtl/channel_model.sv
// Baseband channel emulator: frames head/data/rest bursts, adds saturating LFSR noise, flips symbols on error slots.
// Latency 1 cycle, all outputs registered; IsTransmit=0 in HEAD/DATA stalls counters and phase, REST ignores it.
module channel_model
  import channel_pkg::*;
#(
  parameter int                W          = 4,
  parameter int                NOISE_BITS = 2,
  parameter int                LFSR_W     = 8,
  parameter int                HEAD_LEN   = 5,
  parameter int                FRAME_LEN  = 32,
  parameter int                REST_LEN   = 16,
  parameter int                HEAD_I     = 4,
  parameter int                HEAD_Q     = -4,
  parameter logic [LFSR_W-1:0] SEED_I     = 8'h01,
  parameter logic [LFSR_W-1:0] SEED_Q     = 8'h5A
) (
  input  logic            clk,
  input  logic            reset,
  channel_model_if.slave  bus
);

  localparam int CW = 16;

  state_e              st, st_nxt;
  logic [CW-1:0]       head_cnt, head_nxt;
  logic [CW-1:0]       data_cnt, data_nxt;
  logic [CW-1:0]       rest_cnt, rest_nxt;
  logic [7:0]          err_cnt, err_nxt;
  logic [7:0]          per;
  logic                sym_vld;
  logic [1:0]          ph_out;
  int                  sym_i, sym_q;
  int                  out_i, out_q;
  logic                err_en, err_i, err_q;
  logic signed [W-1:0] noise_i, noise_q;

  noise_lfsr #(.W(W), .LFSR_W(LFSR_W), .NOISE_BITS(NOISE_BITS), .SEED(SEED_I)) u_noise_i (
    .clk   (clk),
    .reset (reset),
    .noise (noise_i)
  );

  noise_lfsr #(.W(W), .LFSR_W(LFSR_W), .NOISE_BITS(NOISE_BITS), .SEED(SEED_Q)) u_noise_q (
    .clk   (clk),
    .reset (reset),
    .noise (noise_q)
  );

  always_comb begin
    st_nxt   = st;
    head_nxt = head_cnt;
    data_nxt = data_cnt;
    rest_nxt = rest_cnt;
    sym_vld  = 1'b0;
    sym_i    = 0;
    sym_q    = 0;
    ph_out   = st;
    unique case (st)
      // The IDLE cycle that sees IsTransmit already carries head symbol 0, so it reports HEAD.
      ST_IDLE: begin
        if (bus.IsTransmit) begin
          sym_vld  = 1'b1;
          sym_i    = HEAD_I;
          sym_q    = HEAD_Q;
          ph_out   = PH_HEAD;
          head_nxt = CW'(1);
          st_nxt   = (HEAD_LEN == 1) ? ST_DATA : ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (bus.IsTransmit) begin
          sym_vld  = 1'b1;
          sym_i    = HEAD_I;
          sym_q    = HEAD_Q;
          head_nxt = head_cnt + 1'b1;
          if (head_cnt == CW'(HEAD_LEN - 1)) st_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.IsTransmit) begin
          sym_vld  = 1'b1;
          sym_i    = int'(bus.I_in);
          sym_q    = int'(bus.Q_in);
          data_nxt = data_cnt + 1'b1;
          if (data_cnt == CW'(FRAME_LEN - 1)) st_nxt = ST_REST;
        end
      end
      ST_REST: begin
        rest_nxt = rest_cnt + 1'b1;
        if (rest_cnt == CW'(REST_LEN - 1)) begin
          st_nxt   = ST_IDLE;
          rest_nxt = '0;
          head_nxt = '0;
          data_nxt = '0;
        end
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    per     = bus.err_period;
    err_en  = bus.has_error && (per != 8'd0);
    err_i   = sym_vld && err_en && (err_cnt == per - 8'd1);
    err_q   = sym_vld && err_en && (err_cnt == (per >> 1));
    err_nxt = err_cnt;
    // Comparing against per-1 with >= also folds a stale count back to 0 after err_period shrinks.
    if (sym_vld && per != 8'd0) begin
      err_nxt = (err_cnt >= per - 8'd1) ? 8'd0 : err_cnt + 8'd1;
    end
    if (st_nxt == ST_REST && st != ST_REST) err_nxt = 8'd0;
    out_i = err_i ? sat_neg(sym_i, W) : sat_add(sym_i, int'(noise_i), W);
    out_q = err_q ? sat_neg(sym_q, W) : sat_add(sym_q, int'(noise_q), W);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st            <= ST_IDLE;
      head_cnt      <= '0;
      data_cnt      <= '0;
      rest_cnt      <= '0;
      err_cnt       <= '0;
      bus.I_out     <= '0;
      bus.Q_out     <= '0;
      bus.out_valid <= 1'b0;
      bus.phase     <= PH_IDLE;
      bus.err_flag  <= 1'b0;
    end else begin
      st            <= st_nxt;
      head_cnt      <= head_nxt;
      data_cnt      <= data_nxt;
      rest_cnt      <= rest_nxt;
      err_cnt       <= err_nxt;
      bus.I_out     <= W'(out_i);
      bus.Q_out     <= W'(out_q);
      bus.out_valid <= sym_vld;
      bus.phase     <= ph_out;
      bus.err_flag  <= err_i | err_q;
    end
  end

endmodule

// File: tb/tb_channel_model.sv
// Scoreboarded bench for channel_model: stimulus pushes expected per-cycle results, a monitor pops and compares.
module tb_channel_model;
  import channel_pkg::*;

  localparam int W = 4;

  typedef struct {
    logic signed [W-1:0] i;
    logic signed [W-1:0] q;
    logic                vld;
    logic [1:0]          ph;
    logic                flg;
    time                 t;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  channel_model_if #(.W(W)) bus ();

  channel_model #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t       sbq[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_li, m_lq;
  int         sym_idx;
  bit         he;
  int         per;
  int         tbl[8] = '{7, -8, 3, -3, 0, 5, -6, 1};

  function automatic logic [7:0] step8(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic int nz(input logic [7:0] s);
    return s[1] ? int'(s[1:0]) - 4 : int'(s[1:0]);
  endfunction

  function automatic int clamp(input int v);
    if (v > 7) return 7;
    if (v < -8) return -8;
    return v;
  endfunction

  function automatic int di(input int mode, input int k);
    return (mode == 1) ? 3 : tbl[k % 8];
  endfunction

  function automatic int dq(input int mode, input int k);
    return (mode == 1) ? -8 : tbl[(k + 3) % 8];
  endfunction

  // kind: 0 idle, 1 head symbol, 2 data symbol, 3 rest, 4 stall in head, 5 stall in data
  task automatic cyc(input bit rst_n, input bit tx, input int kind, input int ii, input int qq);
    exp_t e;
    int   si, sq, slot;
    bit   fi, fq;
    @(negedge clk);
    reset          = rst_n;
    bus.IsTransmit = tx;
    bus.I_in       = W'(ii);
    bus.Q_in       = W'(qq);
    bus.has_error  = he;
    bus.err_period = 8'(per);
    e.t = $time;
    if (!rst_n) begin
      e.i = '0; e.q = '0; e.vld = 1'b0; e.ph = 2'd0; e.flg = 1'b0;
    end else if (kind == 1 || kind == 2) begin
      si   = (kind == 1) ? 4 : ii;
      sq   = (kind == 1) ? -4 : qq;
      slot = (per != 0) ? sym_idx % per : 0;
      fi   = he && per != 0 && slot == per - 1;
      fq   = he && per != 0 && slot == per / 2;
      e.i  = W'(fi ? clamp(-si) : clamp(si + nz(m_li)));
      e.q  = W'(fq ? clamp(-sq) : clamp(sq + nz(m_lq)));
      e.vld = 1'b1;
      e.ph  = 2'(kind);
      e.flg = fi | fq;
      sym_idx++;
    end else begin
      e.i   = W'(nz(m_li));
      e.q   = W'(nz(m_lq));
      e.vld = 1'b0;
      e.ph  = (kind >= 4) ? 2'(kind - 3) : 2'(kind);
      e.flg = 1'b0;
    end
    sbq.push_back(e);
    @(posedge clk);
    if (!rst_n) begin
      m_li = 8'h01; m_lq = 8'h5A; sym_idx = 0;
    end else begin
      m_li = step8(m_li); m_lq = step8(m_lq);
    end
  endtask

  task automatic burst(input int mode, input int stall_at, input int abort_at);
    for (int h = 0; h < 5; h++) cyc(1'b1, 1'b1, 1, 0, 0);
    for (int k = 0; k < 32; k++) begin
      if (k == stall_at) repeat (3) cyc(1'b1, 1'b0, 5, 0, 0);
      if (k == abort_at) begin
        cyc(1'b0, 1'b1, 0, 0, 0);
        return;
      end
      cyc(1'b1, 1'b1, 2, di(mode, k), dq(mode, k));
    end
    sym_idx = 0;
    for (int r = 0; r < 16; r++) cyc(1'b1, 1'b1, 3, 0, 0);
    cyc(1'b1, 1'b0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t m;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0 && sbq[0].t < $time) begin
        m = sbq.pop_front();
        n_tests++;
        if ({bus.I_out, bus.Q_out, bus.out_valid, bus.phase, bus.err_flag} !==
            {m.i, m.q, m.vld, m.ph, m.flg}) begin
          n_fail++;
          $display("FAIL cycle@%0t: got I=%0d Q=%0d vld=%0b ph=%0d ef=%0b, want I=%0d Q=%0d vld=%0b ph=%0d ef=%0b",
                   $time, bus.I_out, bus.Q_out, bus.out_valid, bus.phase, bus.err_flag,
                   m.i, m.q, m.vld, m.ph, m.flg);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish by %0t, want finish earlier", $time);
    $fatal(1);
  end

  initial begin : stim
    bus.has_error  = 1'b0;
    bus.IsTransmit = 1'b0;
    bus.err_period = 8'd0;
    bus.I_in       = '0;
    bus.Q_in       = '0;
    he = 1'b0; per = 0;
    m_li = 8'h01; m_lq = 8'h5A; sym_idx = 0;

    cyc(1'b0, 1'b0, 0, 0, 0);
    cyc(1'b0, 1'b0, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 0, 0);

    he = 1'b0; per = 0; burst(0, -1, -1);   // plain framing, saturation patterns
    he = 1'b1; per = 4; burst(1, 10, -1);   // error slots with a 3-cycle stall mid-data
    he = 1'b1; per = 0; burst(0, -1, -1);   // period 0: never err
    he = 1'b0; per = 4; burst(1, -1, -1);   // errors disabled
    he = 1'b1; per = 1; burst(1, -1, -1);   // both lanes flip every symbol
    he = 1'b1; per = 4; burst(1, -1, 20);   // reset aborts at data_cnt 20
    cyc(1'b1, 1'b0, 0, 0, 0);
    he = 1'b0; per = 0; burst(0, -1, -1);   // full burst after the abort

    repeat (3) @(negedge clk);
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
